// File: rtl/candy_seq_pkg.sv
// Shared types and constants for the candy core control sequencer.
package candy_seq_pkg;

  // Level of rst that holds the sequencer in reset (active-low).
  localparam logic RST_ENABLE = 1'b0;

  // 3-bit sequencer state encoding.
  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6,
    SEQ_ERR    = 3'd7
  } seq_state_e;

  // Width of the wait counter; kept at least 1 bit so a disabled timeout
  // (max_wait == 0) still elaborates.
  function automatic int wait_width(input int max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/candy_seq_wait.sv
// Wait/timeout counter shared by the FETCH and MEM phases. expired flags the
// unready cycle that brings the count to MAX_WAIT, so the FSM leaves for ERR
// on the following edge. A ready input always takes precedence.
module candy_seq_wait
  import candy_seq_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  input  logic ready,
  output logic expired
);

  localparam int            W    = wait_width(MAX_WAIT);
  localparam logic [W-1:0]  LAST = W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [W-1:0] cnt;

  // Count consecutive unready cycles; cleared whenever outside FETCH/MEM.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst == RST_ENABLE) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !ready && (MAX_WAIT > 0) && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (MAX_WAIT > 0) && count && !ready && (cnt == LAST);

endmodule

// File: rtl/candy_seq.sv
// Multi-cycle control sequencer for the candy core. Owns the PC and the
// retired-instruction counter and drives the per-stage enables.
module candy_seq
  import candy_seq_pkg::*;
#(
  parameter int AW       = 16,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             fetch_ready,
  input  logic             mem_ready,
  input  logic             is_mem,
  input  logic             is_halt,
  input  logic             br_taken,
  input  logic [AW-1:0]    br_target,
  output logic [AW-1:0]    pc,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [AW-1:0]    err_pc,
  output logic [CNT_W-1:0] retire_cnt
);

  seq_state_e state;
  logic       in_wait;
  logic       wait_ready;
  logic       wait_expired;

  assign in_wait    = (state == SEQ_FETCH) || (state == SEQ_MEM);
  assign wait_ready = (state == SEQ_FETCH) ? fetch_ready : mem_ready;

  candy_seq_wait #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .count   (in_wait),
    .ready   (wait_ready),
    .expired (wait_expired)
  );

  // State transitions plus pc, retire counter and error-pc capture.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= SEQ_IDLE;
      pc         <= AW'(RESET_PC);
      err_pc     <= '0;
      retire_cnt <= '0;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (start) state <= SEQ_FETCH;
        end
        SEQ_FETCH: begin
          if (fetch_ready) begin
            state <= SEQ_DECODE;
          end else if (wait_expired) begin
            state  <= SEQ_ERR;
            err_pc <= pc;
          end
        end
        SEQ_DECODE: begin
          // A HALT instruction never reaches WB, so it does not retire.
          state <= is_halt ? SEQ_HALT : SEQ_EXEC;
        end
        SEQ_EXEC: begin
          state <= is_mem ? SEQ_MEM : SEQ_WB;
        end
        SEQ_MEM: begin
          if (mem_ready) begin
            state <= SEQ_WB;
          end else if (wait_expired) begin
            state  <= SEQ_ERR;
            err_pc <= pc;
          end
        end
        SEQ_WB: begin
          pc <= br_taken ? br_target : pc + AW'(PC_STEP);
          if (retire_cnt != '1) retire_cnt <= retire_cnt + CNT_W'(1);
          state <= step_mode ? SEQ_IDLE : SEQ_FETCH;
        end
        SEQ_HALT: state <= SEQ_HALT;
        SEQ_ERR:  state <= SEQ_ERR;
        default:  state <= SEQ_IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    if_en  = 1'b0;
    id_en  = 1'b0;
    ex_en  = 1'b0;
    mem_en = 1'b0;
    wb_en  = 1'b0;
    busy   = 1'b1;
    halted = 1'b0;
    err    = 1'b0;
    unique case (state)
      SEQ_IDLE:   busy   = 1'b0;
      SEQ_FETCH:  if_en  = 1'b1;
      SEQ_DECODE: id_en  = 1'b1;
      SEQ_EXEC:   ex_en  = 1'b1;
      SEQ_MEM:    mem_en = 1'b1;
      SEQ_WB:     wb_en  = 1'b1;
      SEQ_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      SEQ_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default:    busy   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_candy_seq.sv
// Directed self-checking bench for candy_seq with default parameters.
module tb_candy_seq;

  localparam int AW    = 16;
  localparam int CNT_W = 16;

  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_IF   = 5'b10000;
  localparam logic [4:0] EN_ID   = 5'b01000;
  localparam logic [4:0] EN_EX   = 5'b00100;
  localparam logic [4:0] EN_MEM  = 5'b00010;
  localparam logic [4:0] EN_WB   = 5'b00001;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             step_mode;
  logic             fetch_ready;
  logic             mem_ready;
  logic             is_mem;
  logic             is_halt;
  logic             br_taken;
  logic [AW-1:0]    br_target;
  logic [AW-1:0]    pc;
  logic             if_en, id_en, ex_en, mem_en, wb_en;
  logic             busy, halted, err;
  logic [AW-1:0]    err_pc;
  logic [CNT_W-1:0] retire_cnt;
  logic [4:0]       en;

  int n_cmp = 0;
  int n_bad = 0;

  assign en = {if_en, id_en, ex_en, mem_en, wb_en};

  always #5 clk = ~clk;

  candy_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_mode   (step_mode),
    .fetch_ready (fetch_ready),
    .mem_ready   (mem_ready),
    .is_mem      (is_mem),
    .is_halt     (is_halt),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc          (pc),
    .if_en       (if_en),
    .id_en       (id_en),
    .ex_en       (ex_en),
    .mem_en      (mem_en),
    .wb_en       (wb_en),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .err_pc      (err_pc),
    .retire_cnt  (retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every output against its reset value.
  task automatic check_reset_state(input string tag);
    check({tag, "_en"},     32'(en),         32'(EN_NONE));
    check({tag, "_pc"},     32'(pc),         32'h0);
    check({tag, "_busy"},   32'(busy),       32'h0);
    check({tag, "_halted"}, 32'(halted),     32'h0);
    check({tag, "_err"},    32'(err),        32'h0);
    check({tag, "_err_pc"}, 32'(err_pc),     32'h0);
    check({tag, "_retire"}, 32'(retire_cnt), 32'h0);
  endtask

  // Apply reset across two edges and release it mid-cycle.
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    #3 rst = 1'b1;
    tick();
  endtask

  // Leave IDLE: start is sampled on the next edge, FETCH follows.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Run one non-memory instruction starting in FETCH with fetch_ready high.
  task automatic do_instr(input string tag, input logic take,
                          input logic [AW-1:0] tgt, input logic [AW-1:0] exp_pc);
    check({tag, "_fetch_en"}, 32'(en), 32'(EN_IF));
    check({tag, "_fetch_pc"}, 32'(pc), 32'(exp_pc));
    tick();
    check({tag, "_decode_en"}, 32'(en), 32'(EN_ID));
    tick();
    check({tag, "_exec_en"}, 32'(en), 32'(EN_EX));
    tick();
    check({tag, "_wb_en"}, 32'(en), 32'(EN_WB));
    br_taken  = take;
    br_target = tgt;
    tick();
    br_taken  = 1'b0;
    br_target = '0;
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL time_limit: observed timeout expected $finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    step_mode   = 1'b0;
    fetch_ready = 1'b1;
    mem_ready   = 1'b1;
    is_mem      = 1'b0;
    is_halt     = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;

    // Reset, then three plain instructions back to back.
    #1;
    check_reset_state("por");
    do_reset();
    check("idle_after_reset_en", 32'(en), 32'(EN_NONE));
    do_start();
    check("first_fetch_busy", 32'(busy), 32'h1);
    do_instr("i0", 1'b0, '0, 16'h0000);
    do_instr("i1", 1'b0, '0, 16'h0001);
    do_instr("i2", 1'b0, '0, 16'h0002);
    check("after3_en",     32'(en),         32'(EN_IF));
    check("after3_pc",     32'(pc),         32'h0003);
    check("after3_retire", 32'(retire_cnt), 32'h3);

    // Memory instruction with mem_ready low for three MEM cycles (8 cycles total).
    is_mem    = 1'b1;
    mem_ready = 1'b0;
    tick();
    check("mem_decode_en", 32'(en), 32'(EN_ID));
    tick();
    check("mem_exec_en", 32'(en), 32'(EN_EX));
    tick();
    check("mem_c1_en", 32'(en), 32'(EN_MEM));
    tick();
    check("mem_c2_en", 32'(en), 32'(EN_MEM));
    tick();
    check("mem_c3_en", 32'(en), 32'(EN_MEM));
    tick();
    check("mem_c4_en", 32'(en), 32'(EN_MEM));
    mem_ready = 1'b1;
    tick();
    check("mem_wb_en", 32'(en), 32'(EN_WB));
    is_mem = 1'b0;
    tick();
    check("mem_next_en",     32'(en),         32'(EN_IF));
    check("mem_next_pc",     32'(pc),         32'h0004);
    check("mem_next_retire", 32'(retire_cnt), 32'h4);

    // Taken branches, then a sequential step that wraps 0xFFFF -> 0x0000.
    do_instr("br40", 1'b1, 16'h0040, 16'h0004);
    check("br40_pc",     32'(pc),         32'h0040);
    check("br40_retire", 32'(retire_cnt), 32'h5);
    do_instr("brff", 1'b1, 16'hFFFF, 16'h0040);
    check("brff_pc", 32'(pc), 32'hFFFF);
    do_instr("wrap", 1'b0, '0, 16'hFFFF);
    check("wrap_pc",     32'(pc),         32'h0000);
    check("wrap_retire", 32'(retire_cnt), 32'h7);

    // Single-step: instruction ends in IDLE and waits for start.
    step_mode = 1'b1;
    do_instr("step", 1'b0, '0, 16'h0000);
    check("step_idle_en",   32'(en),   32'(EN_NONE));
    check("step_idle_busy", 32'(busy), 32'h0);
    check("step_idle_pc",   32'(pc),   32'h0001);
    tick();
    tick();
    check("step_hold_en", 32'(en), 32'(EN_NONE));
    do_start();
    check("step_restart_en", 32'(en), 32'(EN_IF));
    step_mode = 1'b0;

    // HALT in DECODE: halted, no retire, start ignored.
    is_halt = 1'b1;
    tick();
    check("halt_decode_en", 32'(en), 32'(EN_ID));
    tick();
    is_halt = 1'b0;
    check("halt_halted", 32'(halted),     32'h1);
    check("halt_busy",   32'(busy),       32'h0);
    check("halt_en",     32'(en),         32'(EN_NONE));
    check("halt_pc",     32'(pc),         32'h0001);
    check("halt_retire", 32'(retire_cnt), 32'h8);
    do_start();
    check("halt_sticky", 32'(halted), 32'h1);
    check("halt_no_fetch_en", 32'(en), 32'(EN_NONE));

    // Fetch timeout: 15 unready FETCH cycles then ERR.
    do_reset();
    do_start();
    fetch_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check($sformatf("to_fetch_c%0d", i), 32'(en), 32'(EN_IF));
      tick();
    end
    check("to_err",     32'(err),    32'h1);
    check("to_busy",    32'(busy),   32'h0);
    check("to_en",      32'(en),     32'(EN_NONE));
    check("to_err_pc",  32'(err_pc), 32'h0000);
    do_start();
    check("to_err_sticky", 32'(err), 32'h1);
    check("to_start_en",   32'(en),  32'(EN_NONE));

    // fetch_ready on the 15th cycle wins; then a timeout at a non-zero pc.
    do_reset();
    do_start();
    for (int i = 1; i <= 14; i++) tick();
    check("rw_c15_en", 32'(en), 32'(EN_IF));
    fetch_ready = 1'b1;
    tick();
    check("rw_decode_en", 32'(en),  32'(EN_ID));
    check("rw_no_err",    32'(err), 32'h0);
    tick();
    tick();
    br_taken  = 1'b1;
    br_target = 16'h0123;
    tick();
    br_taken  = 1'b0;
    br_target = '0;
    check("rw_pc", 32'(pc), 32'h0123);
    fetch_ready = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    check("rw_err",    32'(err),    32'h1);
    check("rw_err_pc", 32'(err_pc), 32'h0123);
    fetch_ready = 1'b1;

    // Asynchronous reset in the middle of a MEM wait.
    do_reset();
    do_start();
    do_instr("pre", 1'b0, '0, 16'h0000);
    is_mem    = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("arst_mem_en", 32'(en), 32'(EN_MEM));
    #2 rst = 1'b0;
    #1;
    check_reset_state("arst");
    is_mem    = 1'b0;
    mem_ready = 1'b1;
    #2 rst = 1'b1;
    tick();
    do_start();
    check("arst_refetch_en", 32'(en), 32'(EN_IF));
    check("arst_refetch_pc", 32'(pc), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
